// File: rtl/seq_shifter.sv
// Iterative variable-amount shifter: one bit position per clock, supporting
// LSL/LSR/ASR/ROR/ROL with carry-out and zero flags, driven by start/busy/done.
module seq_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sout,
  output logic               cout,
  output logic               zero
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
  localparam logic [WIDTH-1:0]   ACC_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One-position step; returns {bit shifted out, new accumulator}.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] a,
                                            input logic [2:0]       m);
    logic [WIDTH:0] r;
    case (m)
      OP_LSL:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {a[0], 1'b0, a[WIDTH-1:1]};
      OP_ASR:  r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      OP_ROR:  r = {a[0], a[0], a[WIDTH-1:1]};
      OP_ROL:  r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_mode;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_cnt_zero;
  logic               w_is_shift_op;
  logic [WIDTH:0]     w_step;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cnt_zero    = (r_cnt == CNT_ZERO);
  assign w_is_shift_op = (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) ||
                         (op == OP_ROR) || (op == OP_ROL);
  assign w_step        = f_step(r_acc, r_mode);

  // State register; reset dominates any concurrent start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SHIFT;
        else          w_state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (w_cnt_zero) w_state_nxt = S_DONE;
        else            w_state_nxt = S_SHIFT;
      end
      S_DONE: begin
        if (w_accept) w_state_nxt = S_SHIFT;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status decode from the upcoming state so busy/done leave a flop.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_SHIFT: w_busy_nxt = 1'b1;
      S_DONE:  w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Datapath: load on accept, then one step per cycle until the count drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= ACC_ZERO;
      r_cnt  <= CNT_ZERO;
      r_mode <= OP_PASS;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= in;
      r_cnt  <= w_is_shift_op ? shamt : CNT_ZERO;
      r_mode <= op;
      r_cout <= 1'b0;
    end else if ((r_state == S_SHIFT) && !w_cnt_zero) begin
      r_acc  <= w_step[WIDTH-1:0];
      r_cout <= w_step[WIDTH];
      r_cnt  <= r_cnt - CNT_ONE;
    end else begin
      r_acc  <= r_acc;
      r_cnt  <= r_cnt;
      r_mode <= r_mode;
      r_cout <= r_cout;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sout = r_acc;
  assign cout = r_cout;
  assign zero = (r_acc == ACC_ZERO);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=16, SHAMT_W=4).
module tb_seq_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] in_v;
  logic [2:0]  op;
  logic [3:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] sout;
  logic        cout;
  logic        zero;

  int n_chk = 0;
  int n_err = 0;

  seq_shifter #(.WIDTH(16), .SHAMT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in_v),
    .op    (op),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .sout  (sout),
    .cout  (cout),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble inputs after the accept edge, then wait for done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [3:0] s, input int n,
                        input logic [15:0] exp_s, input logic exp_c);
    int edges;
    int bcnt;
    start = 1'b1; op = o; in_v = a; shamt = s;
    cyc;
    start = 1'b0; op = 3'b001; in_v = 16'hDEAD; shamt = 4'hF;
    edges = 0;
    bcnt  = 0;
    while (!done && edges < 40) begin
      if (busy) bcnt++;
      cyc;
      edges++;
    end
    chk({tag, "_lat"},  edges, n + 1);
    chk({tag, "_busyn"}, bcnt, n + 1);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sout"}, {16'd0, sout}, {16'd0, exp_s});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_s == 16'h0000)});
    cyc;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, {16'd0, sout}, {16'd0, exp_s});
  endtask

  initial begin
    int edges;
    int seen_done;
    reset = 1'b1; start = 1'b0; in_v = 16'h0000; op = 3'b000; shamt = 4'h0;
    cyc; cyc;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sout", {16'd0, sout}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    cyc;

    run_op("asr2",  3'b011, 16'h8004, 4'd2,  2, 16'hE001, 1'b0);
    run_op("lsl1",  3'b001, 16'h8001, 4'd1,  1, 16'h0002, 1'b1);
    run_op("lsr1",  3'b010, 16'h0001, 4'd1,  1, 16'h0000, 1'b1);
    run_op("ror4",  3'b100, 16'h000F, 4'd4,  4, 16'hF000, 1'b1);
    run_op("rol1",  3'b101, 16'h8000, 4'd1,  1, 16'h0001, 1'b1);
    run_op("lsr0",  3'b010, 16'h1234, 4'd0,  0, 16'h1234, 1'b0);
    run_op("pass7", 3'b000, 16'h1234, 4'd7,  0, 16'h1234, 1'b0);
    run_op("rsv5",  3'b111, 16'hABCD, 4'd5,  0, 16'hABCD, 1'b0);
    run_op("asr15", 3'b011, 16'h8000, 4'd15, 15, 16'hFFFF, 1'b0);
    run_op("rol15", 3'b101, 16'h8001, 4'd15, 15, 16'hC000, 1'b0);
    run_op("lsl15", 3'b001, 16'hFFFF, 4'd15, 15, 16'h8000, 1'b1);

    // start pulsed during SHIFT must be ignored
    start = 1'b1; op = 3'b001; in_v = 16'h0001; shamt = 4'd3;
    cyc;
    start = 1'b0;
    cyc;
    start = 1'b1; in_v = 16'hFFFF; op = 3'b010; shamt = 4'd1;
    cyc;
    start = 1'b0;
    edges = 2;
    while (!done && edges < 40) begin cyc; edges++; end
    chk("ign_lat",  edges, 4);
    chk("ign_sout", {16'd0, sout}, 32'h0008);
    cyc;
    chk("ign_idle", {31'd0, busy}, 32'd0);

    // start held high: back-to-back accept from DONE
    start = 1'b1; op = 3'b001; in_v = 16'h0001; shamt = 4'd1;
    cyc;
    op = 3'b100; in_v = 16'h0003; shamt = 4'd1;
    edges = 0;
    while (!done && edges < 40) begin cyc; edges++; end
    chk("b2b_lat1",  edges, 2);
    chk("b2b_sout1", {16'd0, sout}, 32'h0002);
    cyc;
    start = 1'b0;
    chk("b2b_busy",  {31'd0, busy}, 32'd1);
    chk("b2b_done0", {31'd0, done}, 32'd0);
    edges = 0;
    while (!done && edges < 40) begin cyc; edges++; end
    chk("b2b_lat2",  edges, 2);
    chk("b2b_sout2", {16'd0, sout}, 32'h8001);
    chk("b2b_cout2", {31'd0, cout}, 32'd1);
    cyc;

    // reset in the 5th SHIFT cycle aborts without done
    start = 1'b1; op = 3'b010; in_v = 16'hFFFF; shamt = 4'd15;
    cyc;
    start = 1'b0;
    cyc; cyc; cyc; cyc;
    chk("abt_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    cyc;
    chk("abt_busy", {31'd0, busy}, 32'd0);
    chk("abt_done", {31'd0, done}, 32'd0);
    chk("abt_sout", {16'd0, sout}, 32'd0);
    chk("abt_cout", {31'd0, cout}, 32'd0);
    chk("abt_zero", {31'd0, zero}, 32'd1);
    cyc;
    chk("rst_start_ign", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      cyc;
      if (done) seen_done = 1;
    end
    chk("abt_nodone", seen_done, 0);
    run_op("asr_post", 3'b011, 16'hFFFE, 4'd1, 1, 16'hFFFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
